// File: rtl/aes_diffusion_seq.sv
// AES diffusion layer, column-serial: ShiftRows+MixColumns forward, InvMixColumns+InvShiftRows inverse.
// Handshake: a transfer happens on a rising edge where valid && ready; valid holds with stable data until taken.
module aes_diffusion_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  input  logic         in_bypass_mix,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  localparam int N_BUSY = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] GRP_MASK = 2'(~(COLS_PER_CYCLE - 1));
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4) ||
      (N_BUSY * COLS_PER_CYCLE != 4)) begin : g_bad_cpc
    $error("aes_diffusion_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state, state_nxt;
  logic [127:0] work, work_nxt;
  logic [1:0]   col_idx, col_idx_nxt;
  logic         inv_q, inv_nxt;
  logic         byp_q, byp_nxt;
  logic [31:0]  lane_out [COLS_PER_CYCLE];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] b [4];
    for (int r = 0; r < 4; r++) a[r] = col[31-8*r -: 8];
    for (int r = 0; r < 4; r++)
      b[r] = xtime(a[r]) ^ xtime(a[(r+1)&3]) ^ a[(r+1)&3] ^ a[(r+2)&3] ^ a[(r+3)&3];
    return {b[0], b[1], b[2], b[3]};
  endfunction

  // 9/B/D/E multiples assembled from the x2, x4, x8 chain of each byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    logic [7:0] b [4];
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      x2    = xtime(a[r]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[r] = x8 ^ a[r];
      mb[r] = x8 ^ x2 ^ a[r];
      md[r] = x8 ^ x4 ^ a[r];
      me[r] = x8 ^ x4 ^ x2;
    end
    for (int r = 0; r < 4; r++)
      b[r] = me[r] ^ mb[(r+1)&3] ^ md[(r+2)&3] ^ m9[(r+3)&3];
    return {b[0], b[1], b[2], b[3]};
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [1:0]   src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? 2'(c - r) : 2'(c + r);
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*int'(src)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] idx);
    return s[127-32*int'(idx) -: 32];
  endfunction

  always_comb begin
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      lane_out[g] = inv_q ? inv_mix_col(get_col(work, col_idx | 2'(g)))
                          : mix_col(get_col(work, col_idx | 2'(g)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      work    <= '0;
      col_idx <= '0;
      inv_q   <= 1'b0;
      byp_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      work    <= work_nxt;
      col_idx <= col_idx_nxt;
      inv_q   <= inv_nxt;
      byp_q   <= byp_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    work_nxt    = work;
    col_idx_nxt = col_idx;
    inv_nxt     = inv_q;
    byp_nxt     = byp_q;
    in_ready    = (state == IDLE);
    out_valid   = (state == DONE);
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          inv_nxt     = in_inv;
          byp_nxt     = in_bypass_mix;
          work_nxt    = in_inv ? in_state : shift_rows(in_state, 1'b0);
          col_idx_nxt = '0;
          state_nxt   = BUSY;
        end
      end
      BUSY: begin
        // A bypassed state spends exactly one settle cycle here, untouched.
        if (byp_q) begin
          state_nxt = DONE;
        end else begin
          for (int c = 0; c < 4; c++) begin
            if ((2'(c) & GRP_MASK) == col_idx)
              work_nxt[127-32*c -: 32] = lane_out[c & (COLS_PER_CYCLE - 1)];
          end
          col_idx_nxt = col_idx + COL_STEP;
          if (col_idx == LAST_COL) state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_state = out_valid ? (inv_q ? shift_rows(work, 1'b1) : work) : '0;

endmodule

// File: tb/tb_aes_diffusion_seq.sv
// Bench for aes_diffusion_seq: three instances (1, 2, 4 columns per cycle) share stimulus and are
// checked every cycle against a byte-matrix model of the AES diffusion layer.
module tb_aes_diffusion_seq;

  localparam int NB [3] = '{4, 2, 1};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] in_state;
  logic         in_inv;
  logic         in_bypass_mix;
  logic         out_ready;
  logic         ir [3];
  logic         ov [3];
  logic [127:0] os [3];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [127:0] exp_q [$];
  bit           inflight [3];
  int           acc [3];
  int           lat [3];
  int           rd [3];

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_diffusion_seq #(.COLS_PER_CYCLE(1)) u_dut_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_state(in_state),
    .in_inv(in_inv), .in_bypass_mix(in_bypass_mix), .out_valid(ov[0]), .out_ready(out_ready),
    .out_state(os[0]));
  aes_diffusion_seq #(.COLS_PER_CYCLE(2)) u_dut_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_state(in_state),
    .in_inv(in_inv), .in_bypass_mix(in_bypass_mix), .out_valid(ov[1]), .out_ready(out_ready),
    .out_state(os[1]));
  aes_diffusion_seq #(.COLS_PER_CYCLE(4)) u_dut_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in_state(in_state),
    .in_inv(in_inv), .in_bypass_mix(in_bypass_mix), .out_valid(ov[2]), .out_ready(out_ready),
    .out_state(os[2]));

  // reference model: state as a 4x4 byte matrix, GF(2^8) product by carry-less multiply + reduction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] model_out(input logic [127:0] s, input logic inv, input logic byp);
    logic [7:0]   m [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   coef [4];
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) m[r][c] = s[127-8*(4*c+r) -: 8];
    if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    if (!inv) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = m[r][(c + r) % 4];
      m = t;
    end
    if (!byp) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          t[r][c] = 8'h00;
          for (int j = 0; j < 4; j++) t[r][c] = t[r][c] ^ gmul(coef[j], m[(r + j) % 4][c]);
        end
      m = t;
    end
    if (inv) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = m[r][(c - r + 4) % 4];
      m = t;
    end
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[127-8*(4*c+r) -: 8] = m[r][c];
    return o;
  endfunction

  function automatic logic [127:0] rep4(input logic [31:0] col);
    return {col, col, col, col};
  endfunction

  task automatic pin(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: model %h, required %h", name, got, want);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ov[d] !== 1'b0 || ir[d] !== 1'b1 || os[d] !== 128'h0) begin
        errors++;
        $display("FAIL %s dut%0d: out_valid=%b in_ready=%b out_state=%h, required 0/1/0",
                 name, d, ov[d], ir[d], os[d]);
      end
    end
  endtask

  // scoreboard / compare process: full cycle-accurate expectation on every negedge
  always @(negedge clk) begin
    bit was_inf [3];
    bit any_acc;
    bit exp_ov;
    if (!rst_n) begin
      exp_q.delete();
      for (int d = 0; d < 3; d++) inflight[d] = 1'b0;
    end else begin
      for (int d = 0; d < 3; d++) begin
        was_inf[d] = inflight[d];
        checks++;
        if (ir[d] !== !was_inf[d]) begin
          errors++;
          $display("FAIL in_ready dut%0d cyc%0d: got %b, required %b", d, cyc, ir[d], !was_inf[d]);
        end
        exp_ov = was_inf[d] && (cyc - acc[d] >= lat[d]);
        checks++;
        if (ov[d] !== exp_ov) begin
          errors++;
          $display("FAIL out_valid dut%0d cyc%0d: got %b, required %b", d, cyc, ov[d], exp_ov);
        end
        if (exp_ov) begin
          checks++;
          if (os[d] !== exp_q[rd[d]]) begin
            errors++;
            $display("FAIL out_state dut%0d cyc%0d: got %h, required %h", d, cyc, os[d], exp_q[rd[d]]);
          end
          if (out_ready) inflight[d] = 1'b0;
        end
      end
      if (in_valid) begin
        any_acc = 1'b0;
        for (int d = 0; d < 3; d++) begin
          if (!was_inf[d]) begin
            any_acc     = 1'b1;
            inflight[d] = 1'b1;
            acc[d]      = cyc + 1;
            lat[d]      = in_bypass_mix ? 1 : NB[d];
            rd[d]       = exp_q.size();
          end
        end
        if (any_acc) exp_q.push_back(model_out(in_state, in_inv, in_bypass_mix));
      end
    end
  end

  // driver tasks: called at posedge+#1
  task automatic wait_idle(input bit rnd_ready);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      done = ir[0] && ir[1] && ir[2];
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_idle timeout at cyc%0d", cyc);
    end
  endtask

  task automatic send(input logic [127:0] st, input logic inv, input logic byp);
    in_valid      = 1'b1;
    in_state      = st;
    in_inv        = inv;
    in_bypass_mix = byp;
    @(posedge clk);
    #1;
    in_valid      = 1'b0;
    in_state      = {$urandom, $urandom, $urandom, $urandom};
    in_inv        = 1'($urandom_range(0, 1));
    in_bypass_mix = 1'($urandom_range(0, 1));
  endtask

  initial begin
    logic [127:0] st;
    rst_n         = 1'b0;
    in_valid      = 1'b0;
    in_state      = '0;
    in_inv        = 1'b0;
    in_bypass_mix = 1'b0;
    out_ready     = 1'b1;
    #1;
    pin("model_fwd", model_out(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 1'b0),
        128'h046681e5e0cb199a48f8d37a2806264c);
    pin("model_inv", model_out(128'h046681e5e0cb199a48f8d37a2806264c, 1'b1, 1'b0),
        128'hd42711aee0bf98f1b8b45de51e415230);
    pin("model_byp", model_out(128'h000102030405060708090a0b0c0d0e0f, 1'b0, 1'b1),
        128'h00050a0f04090e03080d02070c01060b);
    pin("model_byp_inv", model_out(128'h00050a0f04090e03080d02070c01060b, 1'b1, 1'b1),
        128'h000102030405060708090a0b0c0d0e0f);
    pin("model_col_db", model_out(rep4(32'hdb135345), 1'b0, 1'b0), rep4(32'h8e4da1bc));
    pin("model_col_f2", model_out(rep4(32'hf20a225c), 1'b0, 1'b0), rep4(32'h9fdc589d));
    pin("model_col_c6", model_out(rep4(32'hc6c6c6c6), 1'b0, 1'b0), rep4(32'hc6c6c6c6));
    pin("model_col_inv", model_out(rep4(32'h9fdc589d), 1'b1, 1'b0), rep4(32'hf20a225c));
    check_reset_outputs("reset_state");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // directed vectors
    wait_idle(0); send(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 1'b0);
    wait_idle(0); send(128'h046681e5e0cb199a48f8d37a2806264c, 1'b1, 1'b0);
    wait_idle(0); send(rep4(32'hdb135345), 1'b0, 1'b0);
    wait_idle(0); send(rep4(32'h8e4da1bc), 1'b1, 1'b0);
    wait_idle(0); send(rep4(32'hf20a225c), 1'b0, 1'b0);
    wait_idle(0); send(rep4(32'hc6c6c6c6), 1'b1, 1'b0);
    wait_idle(0); send(128'h000102030405060708090a0b0c0d0e0f, 1'b0, 1'b1);
    wait_idle(0); send(128'h00050a0f04090e03080d02070c01060b, 1'b1, 1'b1);

    // backpressure with a competing in_valid held through BUSY/DONE
    wait_idle(0);
    out_ready = 1'b0;
    send(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    in_valid      = 1'b1;
    in_state      = 128'h046681e5e0cb199a48f8d37a2806264c;
    in_inv        = 1'b1;
    in_bypass_mix = 1'b0;
    repeat (11) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;

    // reset in the middle of BUSY
    wait_idle(0);
    send(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_busy");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_idle(0); send(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 1'b0);

    // randomized traffic with random backpressure
    for (int n = 0; n < 80; n++) begin
      wait_idle(1);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      st = {$urandom, $urandom, $urandom, $urandom};
      send(st, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end
    wait_idle(0);
    repeat (3) @(posedge clk);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
